// File: rtl/gate_counter.sv
// rtl/gate_counter.sv - equal-precision gate counter producing the Q1..Q4 counts of the frequency meter
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous reset, active low
//   sig_a    measured signal, asynchronous to clk
//   sig_b    phase-reference signal, asynchronous to clk
//   q1       clk cycles in the actual gate
//   q2       sig_a rising edges in the actual gate
//   q3       clk cycles in the gate with sig_a high
//   q4       clk cycles in the gate with sig_a high and sig_b low
//   valid    one-cycle strobe; q1..q4 and timeout update on this cycle
//   timeout  last result was aborted (q1..q4 are zero); held until the next valid
//   busy     gate open or waiting for its closing edge
module gate_counter #(
    parameter int unsigned GATE_CYCLES    = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_a,
    input  logic        sig_b,
    output logic [31:0] q1,
    output logic [31:0] q2,
    output logic [31:0] q3,
    output logic [31:0] q4,
    output logic        valid,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        WAIT_OPEN = 2'd0,
        OPEN      = 2'd1,
        CLOSING   = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [31:0] GATE_LAST    = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] SAT          = 32'hFFFF_FFFF;

    state_t      state;
    state_t      state_next;

    logic        a_m, a_s, a_d;
    logic        b_m, b_s;
    logic        a_rise;

    logic [31:0] q1w, q2w, q3w, q4w;
    logic [31:0] preset;
    logic [31:0] to_cnt;

    logic        open_gate;
    logic        close_gate;
    logic        abort;
    logic        counting;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != SAT)) ? v + 32'd1 : v;
    endfunction

    // Both inputs see the same synchroniser depth, so the latency cancels
    // out of every count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_m <= 1'b0;
            a_s <= 1'b0;
            a_d <= 1'b0;
            b_m <= 1'b0;
            b_s <= 1'b0;
        end else begin
            a_m <= sig_a;
            a_s <= a_m;
            a_d <= a_s;
            b_m <= sig_b;
            b_s <= b_m;
        end
    end

    assign a_rise = a_s & ~a_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_OPEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        open_gate  = 1'b0;
        close_gate = 1'b0;
        abort      = 1'b0;
        counting   = 1'b0;
        case (state)
            WAIT_OPEN: begin
                // A real edge wins over a coincident timeout.
                if (a_rise) begin
                    open_gate  = 1'b1;
                    state_next = OPEN;
                end else if (to_cnt == TIMEOUT_LAST) begin
                    abort = 1'b1;
                end
            end
            OPEN: begin
                counting = 1'b1;
                // preset becomes GATE_CYCLES at the end of this cycle; an
                // edge here is still counted and does not close the gate.
                if (preset == GATE_LAST) begin
                    state_next = CLOSING;
                end
            end
            CLOSING: begin
                if (a_rise) begin
                    // The closing edge cycle is excluded so Q1 spans whole
                    // sig_a periods.
                    close_gate = 1'b1;
                    state_next = DONE;
                end else if (to_cnt == TIMEOUT_LAST) begin
                    abort      = 1'b1;
                    state_next = WAIT_OPEN;
                end else begin
                    counting = 1'b1;
                end
            end
            DONE: begin
                state_next = WAIT_OPEN;
            end
            default: begin
                state_next = WAIT_OPEN;
            end
        endcase
    end

    // Timeout counter restarts on every state change and after each abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if ((state_next != state) || abort) begin
            to_cnt <= '0;
        end else if ((state == WAIT_OPEN) || (state == CLOSING)) begin
            to_cnt <= to_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1w    <= '0;
            q2w    <= '0;
            q3w    <= '0;
            q4w    <= '0;
            preset <= '0;
        end else if (open_gate) begin
            // The opening edge cycle is gate cycle 1; a_s is known high here.
            q1w    <= 32'd1;
            q2w    <= 32'd1;
            q3w    <= 32'd1;
            q4w    <= {31'd0, ~b_s};
            preset <= 32'd1;
        end else if (counting) begin
            q1w    <= sat_inc(q1w, 1'b1);
            q2w    <= sat_inc(q2w, a_rise);
            q3w    <= sat_inc(q3w, a_s);
            q4w    <= sat_inc(q4w, a_s & ~b_s);
            preset <= sat_inc(preset, 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1      <= '0;
            q2      <= '0;
            q3      <= '0;
            q4      <= '0;
            timeout <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= close_gate | abort;
            if (close_gate) begin
                q1      <= q1w;
                q2      <= q2w;
                q3      <= q3w;
                q4      <= q4w;
                timeout <= 1'b0;
            end else if (abort) begin
                q1      <= '0;
                q2      <= '0;
                q3      <= '0;
                q4      <= '0;
                timeout <= 1'b1;
            end
        end
    end

    assign busy = (state == OPEN) || (state == CLOSING);

endmodule

// File: tb/tb_gate_counter.sv
// tb/tb_gate_counter.sv - self-checking bench for gate_counter
module tb_gate_counter;

    typedef struct {
        logic [31:0] q1;
        logic [31:0] q2;
        logic [31:0] q3;
        logic [31:0] q4;
        logic        to;
    } res_t;

    typedef struct {
        int          period;
        int          high;
        int          delay;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e3;
        logic [31:0] e4;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_a = 1'b0;
    logic        sig_b = 1'b0;
    logic [31:0] q1, q2, q3, q4;
    logic        valid, timeout, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    bit   gen_run    = 1'b0;
    bit   was_run    = 1'b0;
    int   gen_period = 100;
    int   gen_high   = 50;
    int   gen_delay  = 25;
    int   phase      = 0;
    int   start_cyc  = 0;
    logic [127:0] a_hist = '0;

    res_t sb[$];
    int   valid_cycles[$];

    gate_counter #(
        .GATE_CYCLES   (1000),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_a  (sig_a),
        .sig_b  (sig_b),
        .q1     (q1),
        .q2     (q2),
        .q3     (q3),
        .q4     (q4),
        .valid  (valid),
        .timeout(timeout),
        .busy   (busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Waveform generator: sig_a square wave starting high at phase 0,
    // sig_b is sig_a delayed by gen_delay clocks.
    initial forever begin
        @(negedge clk);
        if (gen_run) begin
            if (!was_run) begin
                phase     = 0;
                start_cyc = cyc;
            end
            sig_a = (phase < gen_high);
            phase = (phase + 1 == gen_period) ? 0 : phase + 1;
        end else begin
            sig_a = 1'b0;
        end
        was_run = gen_run;
        a_hist  = {a_hist[126:0], sig_a};
        sig_b   = a_hist[gen_delay];
    end

    // Scoreboard consumer: every valid must match the oldest expectation.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (valid) begin
                valid_cycles.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("q1", q1, e.q1);
                    check("q2", q2, e.q2);
                    check("q3", q3, e.q3);
                    check("q4", q4, e.q4);
                    check("timeout", timeout, e.to);
                end
            end
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: time limit reached, checks so far %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain_remaining", sb.size(), 0);
        sb.delete();
    endtask

    task automatic push_res(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d, input logic t);
        res_t r;
        r.q1 = a; r.q2 = b; r.q3 = c; r.q4 = d; r.to = t;
        sb.push_back(r);
    endtask

    task automatic hard_reset();
        gen_run = 1'b0;
        rst_n   = 1'b0;
        repeat (200) @(negedge clk);
    endtask

    vec_t vecs[5];
    int   rel;
    int   lat;

    initial begin
        vecs[0] = '{100, 50, 25, 32'd1000, 32'd10,  32'd500, 32'd250, 1003};
        vecs[1] = '{300, 90, 25, 32'd1200, 32'd4,   32'd360, 32'd100, 1203};
        vecs[2] = '{250, 200, 25, 32'd1000, 32'd4,  32'd800, 32'd100, 1003};
        vecs[3] = '{7,   3,   2, 32'd1001, 32'd143, 32'd429, 32'd286, 1004};
        vecs[4] = '{10,  1,   0, 32'd1000, 32'd100, 32'd100, 32'd0,   1003};

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_q1", q1, 0);
        check("rst_q2", q2, 0);
        check("rst_q3", q3, 0);
        check("rst_q4", q4, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);

        // Table-driven gates
        for (int i = 0; i < 5; i++) begin
            hard_reset();
            gen_period = vecs[i].period;
            gen_high   = vecs[i].high;
            gen_delay  = vecs[i].delay;
            valid_cycles.delete();
            push_res(vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4, 1'b0);
            rst_n   = 1'b1;
            gen_run = 1'b1;
            wait_sb(3000);
            repeat (20) @(negedge clk);
            check("n_valid", valid_cycles.size(), 1);
            lat = (valid_cycles.size() > 0) ? valid_cycles[0] - start_cyc : -1;
            check("valid_latency", lat, vecs[i].lat);
        end

        // Stuck sig_a: periodic timeout strobes
        hard_reset();
        valid_cycles.delete();
        push_res(0, 0, 0, 0, 1'b1);
        push_res(0, 0, 0, 0, 1'b1);
        rst_n = 1'b1;
        rel   = cyc;
        wait_sb(11000);
        check("stuck_n_valid", valid_cycles.size(), 2);
        if (valid_cycles.size() >= 2) begin
            check("stuck_first", valid_cycles[0] - rel, 5000);
            check("stuck_interval", valid_cycles[1] - valid_cycles[0], 5000);
        end

        // Signal lost mid-gate, then a good gate
        hard_reset();
        gen_period = 100;
        gen_high   = 50;
        gen_delay  = 25;
        rst_n   = 1'b1;
        gen_run = 1'b1;
        repeat (470) @(negedge clk);
        gen_run = 1'b0;
        check("lost_busy", busy, 1);
        push_res(0, 0, 0, 0, 1'b1);
        wait_sb(8000);
        gen_run = 1'b1;
        push_res(1000, 10, 500, 250, 1'b0);
        repeat (500) @(negedge clk);
        check("timeout_held", timeout, 1);
        check("q1_held", q1, 0);
        wait_sb(2000);

        // Reset mid-gate with nonzero held results
        repeat (500) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_q1_before", q1, 1000);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_q1", q1, 0);
        check("mid_rst_q2", q2, 0);
        check("mid_rst_q3", q3, 0);
        check("mid_rst_q4", q4, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (!sig_a) break;
        end
        valid_cycles.delete();
        push_res(1000, 10, 500, 250, 1'b0);
        push_res(1000, 10, 500, 250, 1'b0);
        push_res(1000, 10, 500, 250, 1'b0);
        rst_n = 1'b1;
        wait_sb(4500);
        check("btb_n_valid", valid_cycles.size(), 3);
        if (valid_cycles.size() >= 3) begin
            check("btb_gap1", valid_cycles[1] - valid_cycles[0], 1100);
            check("btb_gap2", valid_cycles[2] - valid_cycles[1], 1100);
        end

        gen_run = 1'b0;
        rst_n   = 1'b0;
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_counter.md
Name: gate_counter

Overview:
- Equal-precision measurement front end of the frequency meter. It produces the four 32-bit counts Q1..Q4 that the downstream processing block turns into frequency, duty cycle and phase difference.
- It synchronises two external signals, SIG_A and SIG_B, and runs a gate that is aligned to SIG_A rising edges.
- At the end of each gate it latches the results and issues a one-cycle VALID strobe.

Parameters:
- GATE_CYCLES, 100_000_000, preset gate length in CLK cycles (1 s at 100 MHz).
- TIMEOUT_CYCLES, 200_000_000, maximum CLK cycles spent waiting for a SIG_A edge before the gate is aborted.

Ports:
- CLK  input  1  100 MHz system clock.
- RST_N  input  1  asynchronous reset, active low.
- SIG_A  input  1  measured signal, asynchronous to CLK.
- SIG_B  input  1  phase-reference signal, asynchronous to CLK.
- Q1  output  32  CLK cycles in actual gate.
- Q2  output  32  SIG_A rising edges in actual gate.
- Q3  output  32  CLK cycles in gate with SIG_A=1.
- Q4  output  32  CLK cycles in gate with SIG_A=1 and SIG_B=0.
- VALID  output  1  one-cycle strobe; Q1..Q4 and TIMEOUT are updated on this cycle.
- TIMEOUT  output  1  last result was aborted; held until the next VALID.
- BUSY  output  1  high in OPEN and CLOSING.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - Q1..Q4=0, VALID=0, TIMEOUT=0, BUSY=0.
  - All internal counters cleared, synchronisers cleared, state=WAIT_OPEN.
  - Reset asserted mid-gate discards the partial counts; no VALID is issued.
- Input conditioning:
  - SIG_A and SIG_B each pass through a 2-FF synchroniser.
  - Rising-edge detect on synchronised A: a_rise = a_s & ~a_d.
  - All counting uses the synchronised signals, so the synchroniser latency cancels out.
- WAIT_OPEN:
  - Timeout counter runs.
  - On a_rise: clear the working counters, enter OPEN. The edge cycle itself counts as cycle 1 (Q1 working=1, Q2 working=1, Q3/Q4 per sampled levels), and the preset counter starts at 1.
- OPEN:
  - Each cycle: Q1w+=1; Q2w+=a_rise; Q3w+=a_s; Q4w+=(a_s & ~b_s); preset+=1.
  - When preset reaches GATE_CYCLES at the end of a cycle, next state is CLOSING.
  - An a_rise on that same cycle is counted and does not close the gate.
- CLOSING:
  - Timeout counter is cleared on entry.
  - Counting continues as in OPEN.
  - On a_rise, that edge cycle is NOT counted: latch Q1..Q4 from the working registers, pulse VALID, set TIMEOUT=0, enter DONE.
- DONE:
  - Lasts one cycle, then WAIT_OPEN.
  - The closing edge never reopens a gate; the next gate opens on a later edge.
- Timeout:
  - If the timeout counter reaches TIMEOUT_CYCLES in WAIT_OPEN or CLOSING: latch Q1..Q4=0, TIMEOUT=1, pulse VALID, go to WAIT_OPEN.
  - Downstream must ignore data when TIMEOUT=1, because Q1=0 would cause a divide by zero.
  - The timeout counter is cleared on every state change.
- Arithmetic:
  - All working counters are 32-bit unsigned and saturate at 32'hFFFF_FFFF; they do not wrap.
  - Q2 equals the number of whole SIG_A periods, so Q1 = Q2·T_A exactly.
- Output timing:
  - Q1..Q4 and TIMEOUT change only on the VALID cycle and hold otherwise.
  - VALID is high for exactly 1 cycle per result.
- BUSY = (state==OPEN | state==CLOSING).

Test Plan:
- Frequency, duty and phase: GATE_CYCLES=1000, TIMEOUT_CYCLES=5000; SIG_A period 100 clocks, 50% duty; SIG_B equals SIG_A delayed 25 clocks -> VALID with Q1=1000, Q2=10, Q3=500, Q4=250, TIMEOUT=0.
- Preset overrun: same setup, SIG_A period 300 clocks, 30% duty -> Q1=1200, Q2=4, Q3=360, TIMEOUT=0. Exactly one VALID, issued 1 cycle after the closing edge is detected.
- Stuck signal: SIG_A held 0 after reset -> VALID with Q1..Q4=0 and TIMEOUT=1 after 5000 cycles; the strobe repeats every ~5000 cycles.
- Signal lost mid-gate: SIG_A stops after 5 periods inside a gate -> timeout result (zeros, TIMEOUT=1). The next good gate returns TIMEOUT=0 with correct counts.
- Reset mid-gate: RST_N pulsed low during OPEN -> all outputs 0 immediately, no VALID. The next full gate yields the values from the first scenario.
- Back-to-back gates: continuous 100-clock SIG_A -> consecutive VALIDs each with Q1=1000, Q2=10. The gap between strobes is 1100 cycles (the closing edge does not reopen).
